// File: rtl/mod_n_pkg.sv
// Shared types and limits for the serial mod-N stream checker.
// Holds the FSM encoding, the bit counter width and the legal parameter ranges.
package mod_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CNT_W       = 16;
    localparam int DIVISOR_MIN = 2;
    localparam int DIVISOR_MAX = 255;
    localparam int BPC_MIN     = 1;
    localparam int BPC_MAX     = 8;

    function automatic int rem_width(input int divisor);
        return (divisor <= 2) ? 1 : $clog2(divisor);
    endfunction

endpackage

// File: rtl/mod_n_bit_step.sv
// One MSB-first bit of long division: r_out = (2*r_in + b_in) mod DIVISOR.
// r_in is always < DIVISOR, so a single conditional subtract is enough.
module mod_n_bit_step #(
    parameter int DIVISOR = 5,
    parameter int REM_W   = 3
) (
    input  logic [REM_W-1:0] r_in,
    input  logic             b_in,
    output logic [REM_W-1:0] r_out
);

    localparam logic [REM_W:0] DIV_C = (REM_W + 1)'(DIVISOR);

    logic [REM_W:0] t;

    always_comb begin
        t = {r_in, b_in};
        if (t >= DIV_C) begin
            t = t - DIV_C;
        end
        r_out = t[REM_W-1:0];
    end

endmodule

// File: rtl/mod_n_stream_checker.sv
// Streaming divisibility checker: folds K bits per accepted beat into a running
// remainder mod DIVISOR and pulses a final result when the last beat is taken.
module mod_n_stream_checker
    import mod_n_pkg::*;
#(
    parameter int  DIVISOR        = 5,
    parameter int  BITS_PER_CYCLE = 1,
    localparam int REM_W          = rem_width(DIVISOR)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [BITS_PER_CYCLE-1:0] in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [REM_W-1:0]          rem_out,
    output logic                      divisible,
    output logic                      done_valid,
    output logic                      done_divisible,
    output logic [CNT_W-1:0]          bit_count,
    output state_e                    state_dbg
);

    if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
        $error("mod_n_stream_checker: DIVISOR %0d out of range", DIVISOR);
    end
    if (BITS_PER_CYCLE < BPC_MIN || BITS_PER_CYCLE > BPC_MAX) begin : g_bad_bpc
        $error("mod_n_stream_checker: BITS_PER_CYCLE %0d out of range", BITS_PER_CYCLE);
    end

    localparam logic [CNT_W:0] K_INC = (CNT_W + 1)'(BITS_PER_CYCLE);

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_div_q, done_div_d;

    logic [REM_W-1:0]   rem_chain [BITS_PER_CYCLE+1];
    logic [REM_W-1:0]   rem_step;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_sat;
    logic               accept;

    // in_data[K-1] arrives first in time, so it feeds the first step of the chain.
    assign rem_chain[0] = rem_q;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        mod_n_bit_step #(
            .DIVISOR (DIVISOR),
            .REM_W   (REM_W)
        ) u_step (
            .r_in  (rem_chain[i]),
            .b_in  (in_data[BITS_PER_CYCLE-1-i]),
            .r_out (rem_chain[i+1])
        );
    end
    assign rem_step = rem_chain[BITS_PER_CYCLE];

    assign cnt_sum = {1'b0, cnt_q} + K_INC;
    assign cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    // Handshake: a beat transfers on any edge where in_valid && in_ready.
    // The producer must hold the beat stable while in_ready is low.
    assign in_ready = (state_q != ST_DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        done_div_d = done_div_q;
        if (clear) begin
            state_d    = ST_IDLE;
            rem_d      = '0;
            cnt_d      = '0;
            done_div_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (accept) begin
                        rem_d = rem_step;
                        cnt_d = cnt_sat;
                        if (in_last) begin
                            state_d    = ST_DONE;
                            done_div_d = (rem_step == '0);
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    state_d    = ST_IDLE;
                    rem_d      = '0;
                    cnt_d      = '0;
                    done_div_d = 1'b0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    rem_d      = '0;
                    cnt_d      = '0;
                    done_div_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            cnt_q      <= '0;
            done_div_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            done_div_q <= done_div_d;
        end
    end

    assign rem_out        = rem_q;
    assign divisible      = (state_q != ST_IDLE) && (rem_q == '0);
    assign done_valid     = (state_q == ST_DONE);
    assign done_divisible = done_div_q;
    assign bit_count      = cnt_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_mod_n_stream_checker.sv
// Bench for mod_n_stream_checker: table-driven K=1 vectors on a DIVISOR=5 instance,
// plus K=4 sequences on DIVISOR=3 and DIVISOR=7 instances including counter saturation.
module tb_mod_n_stream_checker;
    import mod_n_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DIVISOR=5, K=1 instance
    logic        rst, clear, in_valid, in_last;
    logic [0:0]  in_data;
    logic        a_ready, a_div, a_done, a_dd;
    logic [2:0]  a_rem;
    logic [15:0] a_cnt;
    state_e      a_state;

    // K=4 instances (DIVISOR=3 and DIVISOR=7) share one input stream
    logic        rst4, clear4, valid4, last4;
    logic [3:0]  data4;
    logic        b_ready, b_div, b_done, b_dd;
    logic [1:0]  b_rem;
    logic [15:0] b_cnt;
    state_e      b_state;
    logic        c_ready, c_div, c_done, c_dd;
    logic [2:0]  c_rem;
    logic [15:0] c_cnt;
    state_e      c_state;

    mod_n_stream_checker #(.DIVISOR(5), .BITS_PER_CYCLE(1)) u_dut5 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(a_ready), .rem_out(a_rem), .divisible(a_div),
        .done_valid(a_done), .done_divisible(a_dd), .bit_count(a_cnt), .state_dbg(a_state)
    );
    mod_n_stream_checker #(.DIVISOR(3), .BITS_PER_CYCLE(4)) u_dut3 (
        .clk(clk), .rst(rst4), .clear(clear4), .in_valid(valid4), .in_data(data4),
        .in_last(last4), .in_ready(b_ready), .rem_out(b_rem), .divisible(b_div),
        .done_valid(b_done), .done_divisible(b_dd), .bit_count(b_cnt), .state_dbg(b_state)
    );
    mod_n_stream_checker #(.DIVISOR(7), .BITS_PER_CYCLE(4)) u_dut7 (
        .clk(clk), .rst(rst4), .clear(clear4), .in_valid(valid4), .in_data(data4),
        .in_last(last4), .in_ready(c_ready), .rem_out(c_rem), .divisible(c_div),
        .done_valid(c_done), .done_divisible(c_dd), .bit_count(c_cnt), .state_dbg(c_state)
    );

    typedef struct {
        logic        rst, clr, v, d, l;
        logic        rdy;
        logic [7:0]  rem;
        logic        dv, dn, dd;
        logic [15:0] cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [27:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // done_divisible only carries meaning while done_valid is high.
    function automatic logic [27:0] pk(input logic rdy, input logic [7:0] rem, input logic dv,
                                       input logic dn, input logic dd, input logic [15:0] cnt);
        return {rdy, rem, dv, dn, dd & dn, cnt};
    endfunction

    function automatic void add(input logic r, c, v, d, l, rdy, input logic [7:0] rem,
                                input logic dv, dn, dd, input logic [15:0] cnt);
        vec_t x;
        x.rst = r; x.clr = c; x.v = v; x.d = d; x.l = l;
        x.rdy = rdy; x.rem = rem; x.dv = dv; x.dn = dn; x.dd = dd; x.cnt = cnt;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input int idx, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got rdy/rem/div/done/ddiv/cnt=%h required %h", name, idx, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic cyc4(input int idx, input logic r, c, v, input logic [3:0] d, input logic l,
                        input logic [27:0] e3, input logic [27:0] e7);
        rst4 = r; clear4 = c; valid4 = v; data4 = d; last4 = l;
        exp_q.push_back(e3);
        exp_q.push_back(e7);
        @(posedge clk); #1;
        check("k4_div3", idx, pk(b_ready, 8'(b_rem), b_div, b_done, b_dd, b_cnt), exp_q.pop_front());
        check("k4_div7", idx, pk(c_ready, 8'(c_rem), c_div, c_done, c_dd, c_cnt), exp_q.pop_front());
    endtask

    task automatic add_seq_1010();
        add(0,0,1,1,0, 1,1,0,0,0,1);
        add(0,0,1,0,0, 1,2,0,0,0,2);
        add(0,0,1,1,0, 1,0,1,0,0,3);
        add(0,0,1,0,1, 0,0,1,1,1,4);
        add(0,0,0,0,0, 1,0,0,0,0,0);
    endtask

    initial begin
        int r3, r7, cnt;
        logic [3:0] d;
        logic last;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 1'b1; in_last = 1'b1;
        rst4 = 1'b1; clear4 = 1'b0; valid4 = 1'b1; data4 = 4'hF; last4 = 1'b1;
        @(posedge clk); #1;
        check("reset_d5", 0, pk(a_ready, 8'(a_rem), a_div, a_done, a_dd, a_cnt), pk(1,0,0,0,0,0));
        check_bit("reset_d5_ddiv", a_dd, 1'b0);
        check_bit("reset_d5_state", a_state == ST_IDLE, 1'b1);
        check("reset_d3", 0, pk(b_ready, 8'(b_rem), b_div, b_done, b_dd, b_cnt), pk(1,0,0,0,0,0));
        check_bit("reset_d3_state", b_state == ST_IDLE, 1'b1);
        check_bit("reset_d7_state", c_state == ST_IDLE, 1'b1);

        // rst clr v d l | rdy rem div done ddiv cnt
        add_seq_1010();
        // 1,1,1 with two stall cycles between beats
        add(0,0,1,1,0, 1,1,0,0,0,1);
        add(0,0,0,0,0, 1,1,0,0,0,1);
        add(0,0,0,0,0, 1,1,0,0,0,1);
        add(0,0,1,1,0, 1,3,0,0,0,2);
        add(0,0,0,0,0, 1,3,0,0,0,2);
        add(0,0,0,0,0, 1,3,0,0,0,2);
        add(0,0,1,1,1, 0,2,0,1,0,3);
        add(0,0,0,0,0, 1,0,0,0,0,0);
        // valid held through DONE: beat in DONE is held, taken the following cycle
        add(0,0,1,1,0, 1,1,0,0,0,1);
        add(0,0,1,0,1, 0,2,0,1,0,2);
        add(0,0,1,1,0, 1,0,0,0,0,0);
        add(0,0,1,1,0, 1,1,0,0,0,1);
        add(0,0,1,1,0, 1,3,0,0,0,2);
        // clear beats a same-cycle beat
        add(0,1,1,0,0, 1,0,0,0,0,0);
        add(0,0,0,0,0, 1,0,0,0,0,0);
        // single-beat numbers, clear while in DONE
        add(0,0,1,1,1, 0,1,0,1,0,1);
        add(0,1,1,1,0, 1,0,0,0,0,0);
        add(0,0,1,0,1, 0,0,1,1,1,1);
        add(0,0,0,0,0, 1,0,0,0,0,0);
        // reset mid-number, then reset while in DONE
        add(0,0,1,1,0, 1,1,0,0,0,1);
        add(0,0,1,1,0, 1,3,0,0,0,2);
        add(1,0,1,1,1, 1,0,0,0,0,0);
        add(0,0,1,1,1, 0,1,0,1,0,1);
        add(1,0,0,0,0, 1,0,0,0,0,0);
        add_seq_1010();

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; clear = vecs[i].clr; in_valid = vecs[i].v;
            in_data = vecs[i].d; in_last = vecs[i].l;
            exp_q.push_back(pk(vecs[i].rdy, vecs[i].rem, vecs[i].dv, vecs[i].dn, vecs[i].dd, vecs[i].cnt));
            @(posedge clk); #1;
            check("vec", i, pk(a_ready, 8'(a_rem), a_div, a_done, a_dd, a_cnt), exp_q.pop_front());
        end
        in_valid = 1'b0; in_last = 1'b0; rst = 1'b0; clear = 1'b0;

        // 165 = A5h: mod 3 -> 1 then 0, mod 7 -> 3 then 4
        cyc4(0, 0, 0, 1, 4'hA, 0, pk(1,1,0,0,0,4), pk(1,3,0,0,0,4));
        cyc4(1, 0, 0, 1, 4'h5, 1, pk(0,0,1,1,1,8), pk(0,4,0,1,0,8));
        cyc4(2, 0, 0, 0, 4'h0, 0, pk(1,0,0,0,0,0), pk(1,0,0,0,0,0));

        // long random number drives bit_count through saturation
        r3 = 0; r7 = 0; cnt = 0;
        for (int i = 0; i < 16386; i++) begin
            d    = 4'($urandom_range(0, 15));
            last = (i == 16385);
            r3   = (r3 * 16 + int'(d)) % 3;
            r7   = (r7 * 16 + int'(d)) % 7;
            cnt  = (cnt + 4 > 65535) ? 65535 : cnt + 4;
            cyc4(100 + i, 0, 0, 1, d, last,
                 pk(!last, 8'(r3), r3 == 0, last, last && r3 == 0, 16'(cnt)),
                 pk(!last, 8'(r7), r7 == 0, last, last && r7 == 0, 16'(cnt)));
        end
        cyc4(3, 0, 0, 0, 4'h0, 0, pk(1,0,0,0,0,0), pk(1,0,0,0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
